// File: rtl/signed_magnitude_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial signed-magnitude subtractor.
// Pure declarations: no logic, no latency, no flow control.
package signed_magnitude_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    FIX,
    DONE
  } sm_sub_state_e;

  localparam int SM_DEF_N = 8;
  localparam int SM_DEF_W = 2;

  // Sign sits at the MSB of an n-bit signed-magnitude word.
  function automatic int sm_sign_idx(input int n);
    return n - 1;
  endfunction

  function automatic int sm_digits(input int m, input int w);
    return (m + w - 1) / w;
  endfunction

endpackage

// File: rtl/sm_digit_addsub.sv
// Combinational W-bit digit adder/subtractor; cout is the carry (add) or borrow (sub).
// Zero latency; no flow control.
module sm_digit_addsub #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W-1:0] w_y;
  logic         w_c;
  logic [W:0]   w_sum;

  // x - y - bin == x + ~y + ~bin, and a borrow is the absence of a carry.
  always_comb begin
    w_y   = sub ? ~y : y;
    w_c   = sub ? ~cin : cin;
    w_sum = {1'b0, x} + {1'b0, w_y} + {{W{1'b0}}, w_c};
    res   = w_sum[W-1:0];
    cout  = sub ? ~w_sum[W] : w_sum[W];
  end

endmodule

// File: rtl/signed_magnitude_serial_subtractor.sv
// Digit-serial signed-magnitude c = a - b, W bits/cycle; result K+1 cycles after accept, 2K+1 when |b| > |a|.
// Result held in DONE until out_ready; in_ready only in IDLE, so no new operands while busy.
module signed_magnitude_serial_subtractor
  import signed_magnitude_pkg::*;
#(
  parameter int N = SM_DEF_N,
  parameter int W = SM_DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         overflow
);

  localparam int M    = N - 1;
  localparam int SIGN = sm_sign_idx(N);
  localparam int K    = sm_digits(M, W);
  localparam int KW   = K * W;
  localparam int CW   = (K > 1) ? $clog2(K) : 1;

  sm_sub_state_e r_state, w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [KW-1:0] r_a_sh, r_b_sh, r_res, w_res_nxt;
  logic [N-1:0]  r_c;
  logic          r_carry, r_sub, r_sign, r_out_valid, r_ovf;
  logic          w_last, w_fix, w_dig_sub, w_cout, w_ovf_bit, w_sign_fin;
  logic          w_a_sign, w_b_esign;
  logic [W-1:0]  w_dig_x, w_dig_y, w_dig;

  sm_digit_addsub #(.W(W)) u_digit (
    .x    (w_dig_x),
    .y    (w_dig_y),
    .cin  (r_carry),
    .sub  (w_dig_sub),
    .res  (w_dig),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nxt = PASS;
      PASS: if (w_last) w_state_nxt = (r_sub && w_cout) ? FIX : DONE;
      FIX:  if (w_last) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == IDLE);
    w_fix      = (r_state == FIX);
    w_last     = (r_cnt == CW'(K - 1));
    // FIX reuses the digit unit as 0 - partial, i.e. a serial two's-complement negate.
    w_dig_x    = w_fix ? '0 : r_a_sh[W-1:0];
    w_dig_y    = w_fix ? r_res[W-1:0] : r_b_sh[W-1:0];
    w_dig_sub  = w_fix | r_sub;
    w_sign_fin = w_fix ? ~r_sign : r_sign;
    // -0 operands behave as +0.
    w_a_sign   = a[SIGN] & (|a[M-1:0]);
    w_b_esign  = ~(b[SIGN] & (|b[M-1:0]));
  end

  assign w_res_nxt = (r_res >> W) | (KW'(w_dig) << (KW - W));

  generate
    if (KW > M) begin : g_pad
      assign w_ovf_bit = w_res_nxt[M];
    end else begin : g_nopad
      assign w_ovf_bit = w_cout;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_sign      <= 1'b0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a_sh  <= KW'(a[M-1:0]);
          r_b_sh  <= KW'(b[M-1:0]);
          // Matching effective signs add magnitudes; differing signs subtract |b| from |a|.
          r_sub   <= (w_a_sign != w_b_esign);
          r_sign  <= w_a_sign;
          r_carry <= 1'b0;
          r_cnt   <= '0;
        end
        PASS, FIX: begin
          r_a_sh  <= r_a_sh >> W;
          r_b_sh  <= r_b_sh >> W;
          r_res   <= w_res_nxt;
          r_carry <= w_last ? 1'b0 : w_cout;
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          if (w_last && !(r_state == PASS && r_sub && w_cout)) begin
            r_c         <= {w_sign_fin & (|w_res_nxt[M-1:0]), w_res_nxt[M-1:0]};
            r_ovf       <= !w_fix && !r_sub && w_ovf_bit;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign c         = r_c;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule
